// File: rtl/dispatch_queue.sv
// ---------------------------------------------------------------------------
// dispatch_queue
//
// Registered dispatch stage of the Tomasulo core, placed between the fetch
// unit and the RS/LSB/ROB. Decoded instructions are buffered in a small FIFO.
// The head entry reads its operands from the register file. When the ROB and
// the target unit (RS or LSB) both have room, the head is issued: it gets a
// ROB id, its rd is renamed, and a registered dispatch packet is produced.
// One instruction is dispatched per cycle at most.
//
// Optional feature, selected with the macro DISPATCH_CDB_BYPASS_EN:
//   defined   - a CDB broadcast that matches an operand tag is forwarded
//               directly into the packet, so dispatch does not wait.
//   undefined - no forwarding; the head waits one cycle on a tag match and
//               then reads the value the RF has just written back.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   rdy                   global enable; when low, all state freezes
//   flush                 misprediction clear of the whole queue
//   in_flag, in_*         push of one decoded instruction from IF
//   in_full               queue full; IF must not push while high
//   rs1_RF, rs2_RF        head source registers, sent to the RF
//   V1_RF, V2_RF          RF values for rs1/rs2
//   Q1_RF, Q2_RF          RF tags for rs1/rs2 (0 = value ready)
//   rob_full, rs_full,
//   lsb_full              back-pressure from ROB, RS and LSB
//   rob_ava_id            next free ROB id
//   alloc_flag            dispatch fires this cycle (ROB tail advances)
//   rename_flag,
//   rename_rd, rename_id  RF rename request: rd gets tag rename_id
//   cdb_flag, cdb_rob_id,
//   cdb_val               common data bus broadcast
//   out_flag, out_*       registered dispatch packet to the RS/LSB
// ---------------------------------------------------------------------------

// Instruction type codes for memory operations. The core-wide definition
// takes precedence when it is compiled before this file.
`ifndef TYPE_LOAD
`define TYPE_LOAD 3'd1
`endif
`ifndef TYPE_STORE
`define TYPE_STORE 3'd2
`endif

module dispatch_queue #(
    parameter int QBW    = 2,
    parameter int ROB_BW = 4,
    parameter int REG_BW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,

    // Push side (from IF)
    input  logic              in_flag,
    input  logic [REG_BW-1:0] in_rd,
    input  logic [REG_BW-1:0] in_rs1,
    input  logic [REG_BW-1:0] in_rs2,
    input  logic [31:0]       in_A,
    input  logic [5:0]        in_code,
    input  logic [2:0]        in_type,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_jpc,
    output logic              in_full,

    // Register file read
    output logic [REG_BW-1:0] rs1_RF,
    output logic [REG_BW-1:0] rs2_RF,
    input  logic [31:0]       V1_RF,
    input  logic [31:0]       V2_RF,
    input  logic [ROB_BW-1:0] Q1_RF,
    input  logic [ROB_BW-1:0] Q2_RF,

    // Back-pressure and ROB allocation
    input  logic              rob_full,
    input  logic              rs_full,
    input  logic              lsb_full,
    input  logic [ROB_BW-1:0] rob_ava_id,
    output logic              alloc_flag,

    // Rename request to the RF
    output logic              rename_flag,
    output logic [REG_BW-1:0] rename_rd,
    output logic [ROB_BW-1:0] rename_id,

    // Common data bus
    input  logic              cdb_flag,
    input  logic [ROB_BW-1:0] cdb_rob_id,
    input  logic [31:0]       cdb_val,

    // Registered dispatch packet
    output logic              out_flag,
    output logic              out_to_lsb,
    output logic [REG_BW-1:0] out_rd,
    output logic [31:0]       out_A,
    output logic [31:0]       out_V1,
    output logic [31:0]       out_V2,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_jpc,
    output logic [ROB_BW-1:0] out_Q1,
    output logic [ROB_BW-1:0] out_Q2,
    output logic [ROB_BW-1:0] out_rob_id,
    output logic [5:0]        out_code,
    output logic [2:0]        out_type
);

    localparam int              DEPTH      = 1 << QBW;
    localparam logic [QBW:0]    FULL_COUNT = (QBW+1)'(DEPTH);

`ifdef DISPATCH_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [REG_BW-1:0] rd;
        logic [REG_BW-1:0] rs1;
        logic [REG_BW-1:0] rs2;
        logic [31:0]       imm;
        logic [5:0]        code;
        logic [2:0]        itype;
        logic [31:0]       pc;
        logic [31:0]       jpc;
    } entry_t;

    typedef struct packed {
        logic [31:0]       v;
        logic [ROB_BW-1:0] q;
    } operand_t;

    // -----------------------------------------------------------------------
    // Queue storage and pointers
    // -----------------------------------------------------------------------
    entry_t            mem [DEPTH];
    logic [QBW-1:0]    head;
    logic [QBW-1:0]    tail;
    logic [QBW:0]      count;

    entry_t            head_e;
    entry_t            push_e;
    logic              push;
    logic              fire;
    logic              hold;
    logic              lsb_target;
    logic              hit1;
    logic              hit2;
    operand_t          op1;
    operand_t          op2;

    // A CDB match: the broadcast carries the tag this source is waiting on.
    function automatic logic cdb_match(input logic [REG_BW-1:0] rs,
                                       input logic [ROB_BW-1:0] q_rf,
                                       input logic              bus_valid,
                                       input logic [ROB_BW-1:0] bus_id);
        return bus_valid && (rs != '0) && (q_rf != '0) && (bus_id == q_rf);
    endfunction

    // Operand priority: x0 reads as ready zero, then a ready RF value, then
    // (only when forwarding is enabled) the CDB value, otherwise the RF tag.
    function automatic operand_t resolve(input logic [REG_BW-1:0] rs,
                                         input logic [31:0]       v_rf,
                                         input logic [ROB_BW-1:0] q_rf,
                                         input logic              use_cdb,
                                         input logic [31:0]       bus_val);
        operand_t r;
        r.v = '0;
        r.q = '0;
        if (rs != '0) begin
            if (q_rf == '0) begin
                r.v = v_rf;
            end else if (use_cdb) begin
                r.v = bus_val;
            end else begin
                r.v = v_rf;
                r.q = q_rf;
            end
        end
        return r;
    endfunction

    assign head_e  = mem[head];
    assign in_full = (count == FULL_COUNT);

    always_comb begin
        push_e       = '0;
        push_e.rd    = in_rd;
        push_e.rs1   = in_rs1;
        push_e.rs2   = in_rs2;
        push_e.imm   = in_A;
        push_e.code  = in_code;
        push_e.itype = in_type;
        push_e.pc    = in_pc;
        push_e.jpc   = in_jpc;
    end

    // -----------------------------------------------------------------------
    // Issue decision and operand resolve for the head entry
    // -----------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        hit1       = 1'b0;
        hit2       = 1'b0;
        hold       = 1'b0;
        lsb_target = 1'b0;
        op1        = '0;
        op2        = '0;

        hit1       = cdb_match(head_e.rs1, Q1_RF, cdb_flag, cdb_rob_id);
        hit2       = cdb_match(head_e.rs2, Q2_RF, cdb_flag, cdb_rob_id);
        op1        = resolve(head_e.rs1, V1_RF, Q1_RF, BYPASS && hit1, cdb_val);
        op2        = resolve(head_e.rs2, V2_RF, Q2_RF, BYPASS && hit2, cdb_val);

        // Without forwarding, wait one cycle on a match: the RF writes the
        // broadcast value back on this edge and is read clean next cycle.
        hold       = !BYPASS && (hit1 || hit2);

        lsb_target = (head_e.itype == `TYPE_LOAD) || (head_e.itype == `TYPE_STORE);
    end

    assign fire = rdy && !flush && (count != '0) && !rob_full
                  && (lsb_target ? !lsb_full : !rs_full) && !hold;

    // rdy gates the push too, so the queue is fully frozen while rdy is low.
    assign push = rdy && in_flag && !in_full && !flush;

    // -----------------------------------------------------------------------
    // Combinational outputs towards RF and ROB
    // -----------------------------------------------------------------------
    assign rs1_RF      = head_e.rs1;
    assign rs2_RF      = head_e.rs2;
    assign alloc_flag  = fire;
    assign rename_flag = fire && (head_e.rd != '0);
    assign rename_rd   = head_e.rd;
    assign rename_id   = rob_ava_id;

    // -----------------------------------------------------------------------
    // Pointer and occupancy state
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + QBW'(1);
                if (fire) head <= head + QBW'(1);
                case ({push, fire})
                    2'b10:   count <= count + (QBW+1)'(1);
                    2'b01:   count <= count - (QBW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // a push has written it, because fire requires a non-zero count.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_e;
    end

    // -----------------------------------------------------------------------
    // Registered dispatch packet
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_flag   <= 1'b0;
            out_to_lsb <= 1'b0;
            out_rd     <= '0;
            out_A      <= '0;
            out_V1     <= '0;
            out_V2     <= '0;
            out_pc     <= '0;
            out_jpc    <= '0;
            out_Q1     <= '0;
            out_Q2     <= '0;
            out_rob_id <= '0;
            out_code   <= '0;
            out_type   <= '0;
        end else if (rdy) begin
            out_flag <= fire;
            if (fire) begin
                out_to_lsb <= lsb_target;
                out_rd     <= head_e.rd;
                out_A      <= head_e.imm;
                out_V1     <= op1.v;
                out_V2     <= op2.v;
                out_pc     <= head_e.pc;
                out_jpc    <= head_e.jpc;
                out_Q1     <= op1.q;
                out_Q2     <= op2.q;
                out_rob_id <= rob_ava_id;
                out_code   <= head_e.code;
                out_type   <= head_e.itype;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
`ifndef TYPE_LOAD
`define TYPE_LOAD 3'd1
`endif
`ifndef TYPE_STORE
`define TYPE_STORE 3'd2
`endif

module tb_dispatch_queue;

`ifdef DISPATCH_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [2:0] T_ALU   = 3'd0;
    localparam logic [2:0] T_LOAD  = `TYPE_LOAD;
    localparam logic [2:0] T_STORE = `TYPE_STORE;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_flag;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_A, in_pc, in_jpc;
    logic [5:0]  in_code;
    logic [2:0]  in_type;
    logic        in_full;
    logic [4:0]  rs1_RF, rs2_RF;
    logic [31:0] V1_RF, V2_RF;
    logic [3:0]  Q1_RF, Q2_RF;
    logic        rob_full, rs_full, lsb_full;
    logic [3:0]  rob_ava_id;
    logic        alloc_flag, rename_flag;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_id;
    logic        cdb_flag;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_val;
    logic        out_flag, out_to_lsb;
    logic [4:0]  out_rd;
    logic [31:0] out_A, out_V1, out_V2, out_pc, out_jpc;
    logic [3:0]  out_Q1, out_Q2, out_rob_id;
    logic [5:0]  out_code;
    logic [2:0]  out_type;

    dispatch_queue #(.QBW(2), .ROB_BW(4), .REG_BW(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_flag(in_flag), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_A(in_A), .in_code(in_code), .in_type(in_type),
        .in_pc(in_pc), .in_jpc(in_jpc), .in_full(in_full),
        .rs1_RF(rs1_RF), .rs2_RF(rs2_RF), .V1_RF(V1_RF), .V2_RF(V2_RF),
        .Q1_RF(Q1_RF), .Q2_RF(Q2_RF),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_ava_id(rob_ava_id), .alloc_flag(alloc_flag),
        .rename_flag(rename_flag), .rename_rd(rename_rd), .rename_id(rename_id),
        .cdb_flag(cdb_flag), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .out_flag(out_flag), .out_to_lsb(out_to_lsb), .out_rd(out_rd),
        .out_A(out_A), .out_V1(out_V1), .out_V2(out_V2),
        .out_pc(out_pc), .out_jpc(out_jpc),
        .out_Q1(out_Q1), .out_Q2(out_Q2), .out_rob_id(out_rob_id),
        .out_code(out_code), .out_type(out_type)
    );

    always #5 clk = ~clk;

    // Register-file environment: values and rename tags per architectural reg.
    logic [31:0] rf_val [32];
    logic [3:0]  rf_q   [32];
    assign V1_RF = rf_val[rs1_RF];
    assign Q1_RF = rf_q[rs1_RF];
    assign V2_RF = rf_val[rs2_RF];
    assign Q2_RF = rf_q[rs2_RF];

    typedef struct packed {
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a;
        logic [5:0]  code;
        logic [2:0]  typ;
        logic [31:0] pc, jpc;
    } instr_t;

    instr_t mq[$];      // reference queue contents, oldest first
    int checks = 0;
    int errors = 0;

    // Predicted combinational behaviour for the current inputs
    logic        e_fire, e_push, e_full, p_lsb;
    logic [31:0] p_v1, p_v2;
    logic [3:0]  p_q1, p_q2;
    // Expected registered packet
    logic        x_flag, x_lsb;
    logic [4:0]  x_rd;
    logic [31:0] x_a, x_v1, x_v2, x_pc, x_jpc;
    logic [3:0]  x_q1, x_q2, x_rob;
    logic [5:0]  x_code;
    logic [2:0]  x_type;

    task automatic resolve_src(input logic [4:0] r, output logic [31:0] v,
                               output logic [3:0] q, inout logic hold);
        v = '0;
        q = '0;
        if (r != 0) begin
            if (rf_q[r] == 0) begin
                v = rf_val[r];
            end else if (cdb_flag && cdb_rob_id == rf_q[r] && BYPASS) begin
                v = cdb_val;
            end else begin
                if (cdb_flag && cdb_rob_id == rf_q[r]) hold = 1'b1;
                v = rf_val[r];
                q = rf_q[r];
            end
        end
    endtask

    task automatic predict();
        instr_t h;
        logic   hold;
        logic   room;
        hold   = 1'b0;
        e_full = (mq.size() == 4);
        e_push = rdy && in_flag && !e_full && !flush;
        e_fire = 1'b0;
        p_lsb  = 1'b0;
        p_v1 = '0; p_q1 = '0; p_v2 = '0; p_q2 = '0;
        if (mq.size() != 0) begin
            h = mq[0];
            resolve_src(h.rs1, p_v1, p_q1, hold);
            resolve_src(h.rs2, p_v2, p_q2, hold);
            p_lsb  = (h.typ == T_LOAD) || (h.typ == T_STORE);
            room   = p_lsb ? !lsb_full : !rs_full;
            e_fire = rdy && !flush && !rob_full && room && !hold;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        x_flag = 0; x_lsb = 0; x_rd = 0; x_a = 0; x_v1 = 0; x_v2 = 0;
        x_pc = 0; x_jpc = 0; x_q1 = 0; x_q2 = 0; x_rob = 0; x_code = 0; x_type = 0;
    endtask

    // Applied 1 time unit after the edge so the DUT has sampled first.
    task automatic update();
        instr_t h;
        instr_t n;
        if (cdb_flag && cdb_rob_id != 0)
            for (int r = 1; r < 32; r++)
                if (rf_q[r] == cdb_rob_id) begin
                    rf_val[r] = cdb_val;
                    rf_q[r]   = '0;
                end
        if (rdy) begin
            x_flag = e_fire;
            if (e_fire) begin
                h = mq[0];
                x_lsb = p_lsb; x_rd = h.rd; x_a = h.a; x_v1 = p_v1; x_v2 = p_v2;
                x_pc = h.pc; x_jpc = h.jpc; x_q1 = p_q1; x_q2 = p_q2;
                x_rob = rob_ava_id; x_code = h.code; x_type = h.typ;
                if (h.rd != 0) rf_q[h.rd] = rob_ava_id;
                rob_ava_id = (rob_ava_id == 4'd15) ? 4'd1 : rob_ava_id + 4'd1;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (e_fire) void'(mq.pop_front());
                if (e_push) begin
                    n.rd = in_rd; n.rs1 = in_rs1; n.rs2 = in_rs2; n.a = in_A;
                    n.code = in_code; n.typ = in_type; n.pc = in_pc; n.jpc = in_jpc;
                    mq.push_back(n);
                end
            end
        end
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] a,
                             input logic [2:0] typ);
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_A = a; in_type = typ;
        in_code = 6'(a[5:0] ^ 6'h15); in_pc = 32'h1000 + a; in_jpc = 32'h2000 + a;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1; rdy = 1; flush = 0; in_flag = 0;
        rob_full = 0; rs_full = 0; lsb_full = 0; cdb_flag = 0;
        cdb_rob_id = 0; cdb_val = 0; rob_ava_id = 4'd1;
        set_instr(0, 0, 0, 0, T_ALU);
        for (int r = 0; r < 32; r++) begin
            rf_val[r] = (r == 0) ? 32'd0 : 32'h100 * r + 32'(r);
            rf_q[r]   = '0;
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (out_flag !== 1'b0 || in_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold out_flag=%0b in_full=%0b expected 0 0", out_flag, in_full);
        end
        rst = 0;
        #1;
        checks++;
        if (alloc_flag !== 1'b0 || rename_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_alloc alloc=%0b rename=%0b expected 0 0", alloc_flag, rename_flag);
        end
        checks++;
        if ({out_to_lsb, out_rd, out_A, out_V1, out_V2, out_pc, out_jpc, out_Q1, out_Q2,
             out_rob_id, out_code, out_type} !== '0) begin
            errors++;
            $display("FAIL reset_packet rob_id=%0d V1=%h A=%h expected all zero",
                     out_rob_id, out_V1, out_A);
        end
    endtask

    task automatic test_single();
        rob_ava_id = 4'd3;
        in_flag = 1;
        set_instr(5, 0, 0, 32'd7, T_ALU);
        #1;
        checks++;
        if (alloc_flag !== 1'b0) begin
            errors++;
            $display("FAIL single_empty alloc=%0b expected 0", alloc_flag);
        end
        tick();
        in_flag = 0;
        #1;
        checks++;
        if (alloc_flag !== 1'b1 || rename_flag !== 1'b1 || rename_rd !== 5'd5 || rename_id !== 4'd3) begin
            errors++;
            $display("FAIL single_alloc alloc=%0b rename=%0b rd=%0d id=%0d expected 1 1 5 3",
                     alloc_flag, rename_flag, rename_rd, rename_id);
        end
        tick();
        checks++;
        if (out_flag !== 1'b1 || out_V1 !== 32'd0 || out_Q1 !== 4'd0 || out_rob_id !== 4'd3 ||
            out_to_lsb !== 1'b0 || out_A !== 32'd7 || out_rd !== 5'd5) begin
            errors++;
            $display("FAIL single_packet flag=%0b V1=%h Q1=%0d rob=%0d lsb=%0b A=%h rd=%0d expected 1 0 0 3 0 7 5",
                     out_flag, out_V1, out_Q1, out_rob_id, out_to_lsb, out_A, out_rd);
        end
        tick();
        checks++;
        if (out_flag !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse out_flag=%0b expected 0", out_flag);
        end
    endtask

    task automatic test_fill_wrap();
        rs_full = 1;
        for (int i = 0; i < 5; i++) begin
            in_flag = 1;
            set_instr(5'(10 + i), 0, 0, 32'(20 + i), T_ALU);
            #1;
            checks++;
            if (in_full !== (i == 4) || alloc_flag !== 1'b0) begin
                errors++;
                $display("FAIL fill_push%0d in_full=%0b alloc=%0b expected %0b 0",
                         i, in_full, alloc_flag, (i == 4));
            end
            tick();
        end
        in_flag = 0;
        rs_full = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (alloc_flag !== 1'b1 || rename_rd !== 5'(10 + k)) begin
                errors++;
                $display("FAIL drain_alloc%0d alloc=%0b rd=%0d expected 1 %0d",
                         k, alloc_flag, rename_rd, 10 + k);
            end
            tick();
            checks++;
            if (out_flag !== 1'b1 || out_rd !== 5'(10 + k) || out_A !== 32'(20 + k)) begin
                errors++;
                $display("FAIL drain_out%0d flag=%0b rd=%0d A=%0d expected 1 %0d %0d",
                         k, out_flag, out_rd, out_A, 10 + k, 20 + k);
            end
        end
        #1;
        checks++;
        if (alloc_flag !== 1'b0 || in_full !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty alloc=%0b in_full=%0b expected 0 0", alloc_flag, in_full);
        end
        tick();
        checks++;
        if (out_flag !== 1'b0) begin
            errors++;
            $display("FAIL drain_end out_flag=%0b expected 0", out_flag);
        end
    endtask

    task automatic test_lsb_stall();
        lsb_full = 1;
        in_flag = 1;
        set_instr(1, 0, 0, 32'h40, T_LOAD);
        tick();
        in_flag = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (alloc_flag !== 1'b0) begin
                errors++;
                $display("FAIL lsb_stall%0d alloc=%0b expected 0", i, alloc_flag);
            end
            tick();
        end
        lsb_full = 0;
        #1;
        checks++;
        if (alloc_flag !== 1'b1) begin
            errors++;
            $display("FAIL lsb_release alloc=%0b expected 1", alloc_flag);
        end
        tick();
        checks++;
        if (out_flag !== 1'b1 || out_to_lsb !== 1'b1 || out_type !== T_LOAD) begin
            errors++;
            $display("FAIL lsb_packet flag=%0b to_lsb=%0b type=%0d expected 1 1 %0d",
                     out_flag, out_to_lsb, out_type, T_LOAD);
        end
    endtask

    task automatic test_cdb();
        rf_q[7]   = 4'd6;
        rf_val[7] = 32'h55;
        in_flag = 1;
        set_instr(0, 7, 0, 32'h9, T_ALU);
        tick();
        in_flag = 0;
        cdb_flag = 1; cdb_rob_id = 4'd6; cdb_val = 32'h1234;
        #1;
        if (BYPASS) begin
            checks++;
            if (alloc_flag !== 1'b1) begin
                errors++;
                $display("FAIL cdb_bypass_alloc alloc=%0b expected 1", alloc_flag);
            end
            tick();
            cdb_flag = 0;
        end else begin
            checks++;
            if (alloc_flag !== 1'b0) begin
                errors++;
                $display("FAIL cdb_hold alloc=%0b expected 0", alloc_flag);
            end
            tick();
            cdb_flag = 0;
            checks++;
            if (out_flag !== 1'b0) begin
                errors++;
                $display("FAIL cdb_hold_out out_flag=%0b expected 0", out_flag);
            end
            #1;
            tick();
        end
        checks++;
        if (out_flag !== 1'b1 || out_V1 !== 32'h1234 || out_Q1 !== 4'd0) begin
            errors++;
            $display("FAIL cdb_packet flag=%0b V1=%h Q1=%0d expected 1 1234 0",
                     out_flag, out_V1, out_Q1);
        end
    endtask

    task automatic test_flush();
        rs_full = 1;
        for (int i = 0; i < 3; i++) begin
            in_flag = 1;
            set_instr(5'(20 + i), 0, 0, 32'(i), T_ALU);
            tick();
        end
        rs_full = 0;
        flush = 1;
        set_instr(25, 0, 0, 32'h77, T_ALU);
        #1;
        checks++;
        if (alloc_flag !== 1'b0 || rename_flag !== 1'b0) begin
            errors++;
            $display("FAIL flush_alloc alloc=%0b rename=%0b expected 0 0", alloc_flag, rename_flag);
        end
        tick();
        flush = 0;
        in_flag = 0;
        checks++;
        if (out_flag !== 1'b0) begin
            errors++;
            $display("FAIL flush_out out_flag=%0b expected 0", out_flag);
        end
        #1;
        checks++;
        if (alloc_flag !== 1'b0 || in_full !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty alloc=%0b in_full=%0b expected 0 0", alloc_flag, in_full);
        end
        tick();
    endtask

    task automatic test_async_reset();
        in_flag = 1;
        set_instr(3, 0, 0, 32'h31, T_ALU);
        tick();
        set_instr(4, 0, 0, 32'h32, T_ALU);
        tick();
        in_flag = 0;
        rs_full = 1;
        checks++;
        if (out_flag !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup out_flag=%0b expected 1", out_flag);
        end
        #2;
        rst = 1;
        #1;
        rs_full = 0;
        #1;
        checks++;
        if (out_flag !== 1'b0 || alloc_flag !== 1'b0 || in_full !== 1'b0 || out_rob_id !== 4'd0) begin
            errors++;
            $display("FAIL areset_clear flag=%0b alloc=%0b in_full=%0b rob=%0d expected 0 0 0 0",
                     out_flag, alloc_flag, in_full, out_rob_id);
        end
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rdy      = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 29) == 0);
            in_flag  = ($urandom_range(0, 9) < 6);
            rob_full = ($urandom_range(0, 5) == 0);
            rs_full  = ($urandom_range(0, 4) == 0);
            lsb_full = ($urandom_range(0, 4) == 0);
            set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 7)));
            cdb_flag = ($urandom_range(0, 9) < 4);
            r = $urandom_range(1, 7);
            cdb_rob_id = (rf_q[r] != 0) ? rf_q[r] : 4'($urandom_range(1, 15));
            cdb_val = $urandom;
            #1;
            predict();
            checks++;
            if (alloc_flag !== e_fire || in_full !== e_full) begin
                errors++;
                $display("FAIL rnd_alloc cyc=%0d alloc=%0b full=%0b expected %0b %0b",
                         cyc, alloc_flag, in_full, e_fire, e_full);
            end
            if (mq.size() != 0) begin
                checks++;
                if (rename_flag !== (e_fire && mq[0].rd != 0) || rename_rd !== mq[0].rd ||
                    rename_id !== rob_ava_id || rs1_RF !== mq[0].rs1 || rs2_RF !== mq[0].rs2) begin
                    errors++;
                    $display("FAIL rnd_head cyc=%0d ren=%0b rd=%0d id=%0d rs1=%0d rs2=%0d expected %0b %0d %0d %0d %0d",
                             cyc, rename_flag, rename_rd, rename_id, rs1_RF, rs2_RF,
                             (e_fire && mq[0].rd != 0), mq[0].rd, rob_ava_id, mq[0].rs1, mq[0].rs2);
                end
            end
            tick();
            checks++;
            if (out_flag !== x_flag || out_to_lsb !== x_lsb || out_rd !== x_rd || out_A !== x_a ||
                out_V1 !== x_v1 || out_V2 !== x_v2 || out_Q1 !== x_q1 || out_Q2 !== x_q2 ||
                out_rob_id !== x_rob || out_pc !== x_pc || out_jpc !== x_jpc ||
                out_code !== x_code || out_type !== x_type) begin
                errors++;
                $display("FAIL rnd_packet cyc=%0d flag=%0b rd=%0d V1=%h Q1=%0d V2=%h Q2=%0d rob=%0d lsb=%0b expected %0b %0d %h %0d %h %0d %0d %0b",
                         cyc, out_flag, out_rd, out_V1, out_Q1, out_V2, out_Q2, out_rob_id, out_to_lsb,
                         x_flag, x_rd, x_v1, x_q1, x_v2, x_q2, x_rob, x_lsb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_lsb_stall();
        test_cdb();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
